serdes_align_ctrl: RTL and testbench

Word-alignment controller for one ISERDESE2/OSERDESE2 lane pair running on CLKDIV. It sequences the SERDES reset, then compares each deserialized word against a fixed training pattern. On mismatch it issues BITSLIP pulses until the pattern is found for MATCH_COUNT consecutive words, then reports LOCKED and counts word errors. It sits between the SERDES primitives and the link logic and owns the SERDES RST and BITSLIP pins.

---
 rtl/serdes_align_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_serdes_align_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_align_ctrl.sv
// Word-alignment controller for one ISERDESE2/OSERDESE2 lane pair: SERDES reset, then a bitslip search, then lock.
// Optional IDELAY tap sweep when the whole bit window is exhausted: define SERDES_ALIGN_IDELAY_EN.
`timescale 1ns/1ps

module serdes_align_ctrl #(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] PATTERN       = 8'h5C,
    parameter int         RST_CYCLES    = 4,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         BITSLIP_WAIT  = 2,
    parameter int         MATCH_COUNT   = 4
) (
    input  logic                  CLKDIV,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  RETRAIN,
    output logic                  SERDES_RST,
    output logic                  BITSLIP,
    output logic                  BUSY,
    output logic                  LOCKED,
    output logic                  FAIL,
    output logic [3:0]            SLIP_CNT,
    output logic [15:0]           ERR_CNT,
    output logic                  IDELAY_CE,
    output logic                  IDELAY_INC,
    output logic [4:0]            TAP_CNT
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_EXHAUST,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam int CNT_MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > BITSLIP_WAIT) ? CNT_MAX_A : BITSLIP_WAIT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int MATCH_W   = $clog2(MATCH_COUNT + 1);

    localparam logic [CNT_W-1:0]      RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      WAIT_LAST   = CNT_W'(BITSLIP_WAIT - 1);
    localparam logic [MATCH_W-1:0]    MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [3:0]            SLIP_MAX    = 4'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] PAT         = PATTERN[DATA_WIDTH-1:0];

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic               word_match;

    assign word_match = (DATA_IN == PAT);

`ifdef SERDES_ALIGN_IDELAY_EN
    assign IDELAY_INC = 1'b1;
`else
    assign IDELAY_CE  = 1'b0;
    assign IDELAY_INC = 1'b0;
    assign TAP_CNT    = 5'd0;
`endif

    // NOTE: reset is sampled on the clock edge (synchronous), and all state uses <= so every
    // branch sees the pre-edge values of the counters it compares against.
    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            state      <= ST_RESET;
            cnt        <= '0;
            match_cnt  <= '0;
            SERDES_RST <= 1'b1;
            BITSLIP    <= 1'b0;
            BUSY       <= 1'b1;
            LOCKED     <= 1'b0;
            FAIL       <= 1'b0;
            SLIP_CNT   <= 4'd0;
            ERR_CNT    <= 16'd0;
`ifdef SERDES_ALIGN_IDELAY_EN
            IDELAY_CE  <= 1'b0;
            TAP_CNT    <= 5'd0;
`endif
        end else if (RETRAIN && state != ST_RESET) begin
            // Restart the search without touching the SERDES reset pin.
            state     <= ST_SETTLE;
            cnt       <= '0;
            match_cnt <= '0;
            BITSLIP   <= 1'b0;
            BUSY      <= 1'b1;
            LOCKED    <= 1'b0;
            FAIL      <= 1'b0;
            SLIP_CNT  <= 4'd0;
            ERR_CNT   <= 16'd0;
`ifdef SERDES_ALIGN_IDELAY_EN
            IDELAY_CE <= 1'b0;
            TAP_CNT   <= 5'd0;
`endif
        end else begin
            BITSLIP <= 1'b0;
`ifdef SERDES_ALIGN_IDELAY_EN
            IDELAY_CE <= 1'b0;
`endif
            case (state)
                ST_RESET: begin
                    if (cnt == RST_LAST) begin
                        state      <= ST_SETTLE;
                        cnt        <= '0;
                        SERDES_RST <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state     <= ST_CHECK;
                        cnt       <= '0;
                        match_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (word_match) begin
                        if (match_cnt == MATCH_LAST) begin
                            state  <= ST_LOCKED;
                            LOCKED <= 1'b1;
                            BUSY   <= 1'b0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt <= '0;
                        if (SLIP_CNT < SLIP_MAX) begin
                            state    <= ST_SLIP;
                            BITSLIP  <= 1'b1;
                            SLIP_CNT <= SLIP_CNT + 4'd1;
                        end else begin
                            state <= ST_EXHAUST;
                        end
                    end
                end
                ST_SLIP: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    // ISERDES output is stale for a few words after a slip or tap step.
                    if (cnt == WAIT_LAST) begin
                        state <= ST_CHECK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_EXHAUST: begin
`ifdef SERDES_ALIGN_IDELAY_EN
                    if (TAP_CNT != 5'd31) begin
                        state     <= ST_WAIT;
                        cnt       <= '0;
                        IDELAY_CE <= 1'b1;
                        TAP_CNT   <= TAP_CNT + 5'd1;
                        SLIP_CNT  <= 4'd0;
                    end else begin
                        state <= ST_FAIL;
                        FAIL  <= 1'b1;
                        BUSY  <= 1'b0;
                    end
`else
                    state <= ST_FAIL;
                    FAIL  <= 1'b1;
                    BUSY  <= 1'b0;
`endif
                end
                ST_LOCKED: begin
                    if (!word_match && ERR_CNT != 16'hFFFF) begin
                        ERR_CNT <= ERR_CNT + 16'd1;
                    end
                end
                ST_FAIL: begin
                    state <= ST_FAIL;
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Directed bench for serdes_align_ctrl with a rotating-word ISERDES model; build with
// SERDES_ALIGN_IDELAY_EN defined to exercise the IDELAY sweep instead of plain exhaustion.
`timescale 1ns/1ps

module tb_serdes_align_ctrl;

    logic        CLKDIV;
    logic        RST;
    logic [7:0]  DATA_IN;
    logic        RETRAIN;
    logic        SERDES_RST;
    logic        BITSLIP;
    logic        BUSY;
    logic        LOCKED;
    logic        FAIL;
    logic [3:0]  SLIP_CNT;
    logic [15:0] ERR_CNT;
    logic        IDELAY_CE;
    logic        IDELAY_INC;
    logic [4:0]  TAP_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus controls, written only by the main initial block.
    logic       rot_mode   = 1'b0;
    logic [7:0] fixed_word = 8'h5C;
    int         start_off  = 0;
    int         slip_base  = 0;

    // Monitor totals, written only by the negedge monitor.
    int cyc        = 0;
    int slip_total = 0;
    int ce_total   = 0;
    int short_gap  = 0;
    int last_slip  = -100;

    serdes_align_ctrl dut (
        .CLKDIV     (CLKDIV),
        .RST        (RST),
        .DATA_IN    (DATA_IN),
        .RETRAIN    (RETRAIN),
        .SERDES_RST (SERDES_RST),
        .BITSLIP    (BITSLIP),
        .BUSY       (BUSY),
        .LOCKED     (LOCKED),
        .FAIL       (FAIL),
        .SLIP_CNT   (SLIP_CNT),
        .ERR_CNT    (ERR_CNT),
        .IDELAY_CE  (IDELAY_CE),
        .IDELAY_INC (IDELAY_INC),
        .TAP_CNT    (TAP_CNT)
    );

    initial begin
        CLKDIV = 1'b0;
        forever #5 CLKDIV = ~CLKDIV;
    end

    // ISERDES model: each BITSLIP rotates the received word by one more bit.
    int         rot_off;
    logic [15:0] rot_dbl;
    always_comb begin
        rot_off = (start_off + slip_total - slip_base) & 7;
        rot_dbl = {8'h5C, 8'h5C} << rot_off;
        DATA_IN = rot_mode ? rot_dbl[15:8] : fixed_word;
    end

    always @(negedge CLKDIV) begin
        cyc <= cyc + 1;
        if (BITSLIP === 1'b1) begin
            if (cyc - last_slip < 4) short_gap <= short_gap + 1;
            last_slip  <= cyc;
            slip_total <= slip_total + 1;
        end
        if (IDELAY_CE === 1'b1) ce_total <= ce_total + 1;
    end

    task automatic tick();
        @(posedge CLKDIV);
        #1;
    endtask

    task automatic pulse_retrain();
        RETRAIN = 1'b1;
        tick();
        RETRAIN = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        RETRAIN = 1'b1;
        tick();
        RETRAIN = 1'b0;
        tick();
        n_checks++; if (SERDES_RST !== 1'b1) begin n_fail++; $display("FAIL reset_serdes_rst: got %b expected 1", SERDES_RST); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", BUSY); end
        n_checks++; if ({BITSLIP, LOCKED, FAIL, IDELAY_CE} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {BITSLIP, LOCKED, FAIL, IDELAY_CE}); end
        n_checks++; if (SLIP_CNT !== 4'd0 || ERR_CNT !== 16'd0 || TAP_CNT !== 5'd0) begin n_fail++; $display("FAIL reset_counters: got slip=%0d err=%0d tap=%0d expected 0/0/0", SLIP_CNT, ERR_CNT, TAP_CNT); end
    endtask

    // Releases RST and checks the SERDES reset width and the time to lock on a clean pattern.
    task automatic release_and_lock(input string tag);
        int n_rst;
        int n_lock;
        int slips0;
        slips0 = slip_total;
        RST = 1'b0;
        n_rst = 0;
        while (SERDES_RST === 1'b1 && n_rst < 20) begin
            n_rst++;
            tick();
        end
        n_checks++; if (n_rst != 4) begin n_fail++; $display("FAIL %s_serdes_rst_width: got %0d expected 4", tag, n_rst); end
        n_lock = 0;
        while (LOCKED !== 1'b1 && n_lock < 100) begin
            tick();
            n_lock++;
        end
        n_checks++; if (n_lock != 12) begin n_fail++; $display("FAIL %s_lock_latency: got %0d expected 12", tag, n_lock); end
        n_checks++; if (LOCKED !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL %s_locked_state: got locked=%b busy=%b expected 1/0", tag, LOCKED, BUSY); end
        n_checks++; if (SLIP_CNT !== 4'd0) begin n_fail++; $display("FAIL %s_slip_cnt: got %0d expected 0", tag, SLIP_CNT); end
        n_checks++; if (slip_total != slips0) begin n_fail++; $display("FAIL %s_no_bitslip: got %0d pulses expected 0", tag, slip_total - slips0); end
    endtask

    task automatic test_clean_lock();
        rot_mode   = 1'b0;
        fixed_word = 8'h5C;
        release_and_lock("clean");
    endtask

    task automatic test_error_retrain();
        int n_lock;
        bit saw_rst;
        fixed_word = 8'hFF;
        repeat (3) tick();
        fixed_word = 8'h5C;
        n_checks++; if (ERR_CNT !== 16'd3) begin n_fail++; $display("FAIL err_cnt: got %0d expected 3", ERR_CNT); end
        repeat (4) tick();
        n_checks++; if (ERR_CNT !== 16'd3 || LOCKED !== 1'b1) begin n_fail++; $display("FAIL err_hold: got err=%0d locked=%b expected 3/1", ERR_CNT, LOCKED); end
        pulse_retrain();
        n_checks++; if (LOCKED !== 1'b0 || ERR_CNT !== 16'd0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL retrain_clear: got locked=%b err=%0d busy=%b expected 0/0/1", LOCKED, ERR_CNT, BUSY); end
        saw_rst = 1'b0;
        n_lock = 0;
        while (LOCKED !== 1'b1 && n_lock < 100) begin
            if (SERDES_RST !== 1'b0) saw_rst = 1'b1;
            tick();
            n_lock++;
        end
        n_checks++; if (saw_rst) begin n_fail++; $display("FAIL retrain_serdes_rst: got 1 expected 0"); end
        n_checks++; if (n_lock != 12) begin n_fail++; $display("FAIL relock_latency: got %0d expected 12", n_lock); end
    endtask

    task automatic test_bitslip_search();
        int slips0;
        int gaps0;
        int n;
        slips0    = slip_total;
        gaps0     = short_gap;
        slip_base = slip_total;
        start_off = 3;
        rot_mode  = 1'b1;
        pulse_retrain();
        n = 0;
        while (LOCKED !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL bitslip_lock: got %b expected 1", LOCKED); end
        n_checks++; if (slip_total - slips0 != 5) begin n_fail++; $display("FAIL bitslip_pulses: got %0d expected 5", slip_total - slips0); end
        n_checks++; if (SLIP_CNT !== 4'd5) begin n_fail++; $display("FAIL bitslip_slip_cnt: got %0d expected 5", SLIP_CNT); end
        n_checks++; if (short_gap != gaps0) begin n_fail++; $display("FAIL bitslip_spacing: got %0d short gaps expected 0", short_gap - gaps0); end
    endtask

`ifndef SERDES_ALIGN_IDELAY_EN
    task automatic test_exhaust();
        int slips0;
        int n;
        slips0     = slip_total;
        rot_mode   = 1'b0;
        fixed_word = 8'h00;
        pulse_retrain();
        n = 0;
        while (FAIL !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        n_checks++; if (FAIL !== 1'b1 || BUSY !== 1'b0 || LOCKED !== 1'b0) begin n_fail++; $display("FAIL exhaust_state: got fail=%b busy=%b locked=%b expected 1/0/0", FAIL, BUSY, LOCKED); end
        n_checks++; if (slip_total - slips0 != 7) begin n_fail++; $display("FAIL exhaust_pulses: got %0d expected 7", slip_total - slips0); end
        n_checks++; if (SLIP_CNT !== 4'd7) begin n_fail++; $display("FAIL exhaust_slip_cnt: got %0d expected 7", SLIP_CNT); end
        repeat (50) tick();
        n_checks++; if (slip_total - slips0 != 7 || FAIL !== 1'b1) begin n_fail++; $display("FAIL exhaust_hold: got pulses=%0d fail=%b expected 7/1", slip_total - slips0, FAIL); end
        n_checks++; if (ce_total != 0 || IDELAY_INC !== 1'b0 || TAP_CNT !== 5'd0) begin n_fail++; $display("FAIL idelay_off: got ce=%0d inc=%b tap=%0d expected 0/0/0", ce_total, IDELAY_INC, TAP_CNT); end
    endtask
`else
    task automatic test_idelay_sweep();
        int slips0;
        int ce0;
        int n;
        slips0     = slip_total;
        ce0        = ce_total;
        rot_mode   = 1'b0;
        fixed_word = 8'h00;
        pulse_retrain();
        n = 0;
        while (ce_total == ce0 && n < 200) begin
            tick();
            n++;
        end
        n_checks++; if (slip_total - slips0 != 7) begin n_fail++; $display("FAIL idelay_first_slips: got %0d expected 7", slip_total - slips0); end
        n_checks++; if (TAP_CNT !== 5'd1 || SLIP_CNT !== 4'd0) begin n_fail++; $display("FAIL idelay_first_step: got tap=%0d slip=%0d expected 1/0", TAP_CNT, SLIP_CNT); end
        n = 0;
        while (FAIL !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        n_checks++; if (FAIL !== 1'b1 || TAP_CNT !== 5'd31) begin n_fail++; $display("FAIL idelay_fail: got fail=%b tap=%0d expected 1/31", FAIL, TAP_CNT); end
        n_checks++; if (ce_total - ce0 != 31 || slip_total - slips0 != 224) begin n_fail++; $display("FAIL idelay_totals: got ce=%0d slips=%0d expected 31/224", ce_total - ce0, slip_total - slips0); end
        n_checks++; if (IDELAY_INC !== 1'b1) begin n_fail++; $display("FAIL idelay_inc: got %b expected 1", IDELAY_INC); end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        slip_base = slip_total;
        start_off = 3;
        rot_mode  = 1'b1;
        pulse_retrain();
        n = 0;
        while (slip_total - slip_base < 2 && n < 200) begin
            tick();
            n++;
        end
        n_checks++; if (slip_total - slip_base != 2) begin n_fail++; $display("FAIL mid_two_slips: got %0d expected 2", slip_total - slip_base); end
        RST = 1'b1;
        tick();
        n_checks++; if (SERDES_RST !== 1'b1 || BITSLIP !== 1'b0 || SLIP_CNT !== 4'd0) begin n_fail++; $display("FAIL mid_reset: got srst=%b bitslip=%b slip=%0d expected 1/0/0", SERDES_RST, BITSLIP, SLIP_CNT); end
        n_checks++; if (BUSY !== 1'b1 || LOCKED !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got busy=%b locked=%b expected 1/0", BUSY, LOCKED); end
        rot_mode   = 1'b0;
        fixed_word = 8'h5C;
        tick();
        release_and_lock("restart");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST     = 1'b1;
        RETRAIN = 1'b0;
        test_reset();
        test_clean_lock();
        test_error_retrain();
        test_bitslip_search();
`ifndef SERDES_ALIGN_IDELAY_EN
        test_exhaust();
`else
        test_idelay_sweep();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
